// File: rtl/alu_pkg.sv
// Shared constants for seq_alu: opcodes, iterative FSM states, default width.
package alu_pkg;
  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FINISH} state_t;
endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes with a sign fix-up on the last step.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             uns_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             fin_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t             st_q, st_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [WIDTH-1:0]   b_q, a_q, ua, ub, quo, rem;
  logic               div_q, pneg_q, rneg_q, dz_q;
  logic               a_neg, b_neg;
  logic [WIDTH:0]     sum, rsh, diff;

  assign a_neg = !uns_i && a_i[WIDTH-1];
  assign b_neg = !uns_i && b_i[WIDTH-1];
  assign ua    = a_neg ? -a_i : a_i;
  assign ub    = b_neg ? -b_i : b_i;

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    rsh   = p_q[2*WIDTH-1:WIDTH-1];
    diff  = rsh - {1'b0, b_q};
    case (st_q)
      ST_IDLE: if (start_i) begin
        st_d  = ST_ITER;
        cnt_d = '0;
        p_d   = {{WIDTH{1'b0}}, ua};
      end
      ST_ITER: begin
        if (div_q)
          p_d = diff[WIDTH] ? {rsh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else
          p_d = {sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          st_d  = ST_FINISH;
          cnt_d = '0;
        end
      end
      ST_FINISH: st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      p_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      pneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
      if (st_q == ST_IDLE && start_i) begin
        a_q    <= a_i;
        b_q    <= ub;
        div_q  <= div_i;
        pneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        dz_q   <= (b_i == '0);
      end
    end
  end

  // Final values are taken from p_d so they can be registered on the last ITER edge
  always_comb begin
    prod = pneg_q ? -p_d : p_d;
    quo  = pneg_q ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
    rem  = rneg_q ? -p_d[2*WIDTH-1:WIDTH] : p_d[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      {hi_o, lo_o} = prod;
    end else if (dz_q) begin
      hi_o = a_q;
      lo_o = '1;
    end else begin
      hi_o = rem;
      lo_o = quo;
    end
  end

  assign busy_o = (st_q != ST_IDLE);
  assign fin_o  = (st_q == ST_ITER) && (cnt_q == CW'(WIDTH - 1));
  assign done_o = (st_q == ST_FINISH);
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, optional iterative mul/div.
// Define SEQ_ALU_MULDIV_EN to build the multiply/divide engine and hi/lo.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic             acc, is_md, md_busy, md_fin, md_done;
  logic [WIDTH-1:0] md_hi, md_lo, alu_r;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, done_q;

  assign acc = start && !md_busy;

`ifdef SEQ_ALU_MULDIV_EN
  logic [WIDTH-1:0] hi_q, lo_q;

  assign is_md = (ALUOperation[3:2] == 2'b10);

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (acc && is_md),
    .div_i   (ALUOperation[1]),
    .uns_i   (ALUOperation[0]),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (md_busy),
    .fin_o   (md_fin),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_fin) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  assign is_md   = 1'b0;
  assign md_busy = 1'b0;
  assign md_fin  = 1'b0;
  assign md_done = 1'b0;
  assign md_hi   = '0;
  assign md_lo   = '0;
  assign hi      = '0;
  assign lo      = '0;
`endif

  // Unused codes fall to the default and produce 0
  always_comb begin
    alu_r = '0;
    case (ALUOperation)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_ADD:  alu_r = a + b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOR:  alu_r = ~(a | b);
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB:  alu_r = a - b;
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= acc && !is_md;
      if (acc && !is_md) begin
        res_q  <= alu_r;
        zero_q <= (alu_r == '0);
      end else if (md_fin) begin
        res_q  <= md_lo;
        zero_q <= (md_lo == '0);
      end
    end
  end

  assign busy      = md_busy;
  assign done      = done_q | md_done;
  assign ALUResult = res_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a wide-arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [3:0]   ALUOperation;
  logic [W-1:0] a, b;
  logic         busy, done, zero;
  logic [W-1:0] ALUResult, hi, lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] hi_m, lo_m;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ALUOperation (ALUOperation),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .ALUResult    (ALUResult),
    .zero         (zero),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: result from plain arithmetic; updates hi_m/lo_m for mul/div
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output bit md);
    logic [2*W-1:0] p;
    int sx, sy;
    md = 1'b0;
    r  = '0;
    sx = x;
    sy = y;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x + y;
      4'd3: r = x ^ y;
      4'd4: r = ~(x | y);
      4'd5: r = (x < y) ? 32'd1 : 32'd0;
      4'd6: r = x - y;
      4'd7: r = (sx < sy) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
      4'd8: begin
        md = 1'b1;
        p = longint'(sx) * longint'(sy);
        {hi_m, lo_m} = p;
      end
      4'd9: begin
        md = 1'b1;
        p = {32'b0, x} * {32'b0, y};
        {hi_m, lo_m} = p;
      end
      4'd10: begin
        md = 1'b1;
        if (y == 0) begin lo_m = '1; hi_m = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo_m = x; hi_m = '0; end
        else begin lo_m = sx / sy; hi_m = sx % sy; end
      end
      4'd11: begin
        md = 1'b1;
        if (y == 0) begin lo_m = '1; hi_m = x; end
        else begin lo_m = x / y; hi_m = x % y; end
      end
`endif
      default: r = '0;
    endcase
    if (md) r = lo_m;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called right after a negedge; drives the request and watches the response
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] er;
    bit md;
    int lat, npulse, last;
    model(op, x, y, er, md);
    ALUOperation = op; a = x; b = y; start = 1'b1;
    lat = 0; npulse = 0;
    last = md ? W + 2 : 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (done) begin npulse++; if (lat == 0) lat = k; end
      if (k == 1) chk("busy_k1", busy, md);
      if (md && k == W + 1) chk("busy_fin", busy, 1);
      if (k == last) chk("busy_end", busy, 0);
      if (k == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; ALUOperation = 4'($urandom);
      end
      if (poke && k == 4) begin start = 1'b1; ALUOperation = 4'b0010; end
      if (poke && k == 5) start = 1'b0;
    end
    chk($sformatf("lat_op%0d", op), lat, md ? W + 1 : 1);
    chk($sformatf("npulse_op%0d", op), npulse, 1);
    chk($sformatf("res_op%0d", op), ALUResult, er);
    chk($sformatf("zero_op%0d", op), zero, er == 0);
    chk($sformatf("hi_op%0d", op), hi, hi_m);
    chk($sformatf("lo_op%0d", op), lo, lo_m);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_res"},  ALUResult, 0);
    chk({pfx, "_zero"}, zero, 1);
    chk({pfx, "_hi"},   hi, 0);
    chk({pfx, "_lo"},   lo, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b1; start = 1'b0; ALUOperation = '0; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'b0111, 32'h8000_0000, 32'd1, 0);
    run_op(4'b0101, 32'h8000_0000, 32'd1, 0);
    run_op(4'b1000, -32'd3, 32'd7, 1);
    run_op(4'b1010, -32'd7, 32'd2, 0);
    run_op(4'b1011, 32'd7, 32'd0, 0);
    run_op(4'b1000, 32'd3, 32'd4, 0);
    run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'b1101, 32'd9, 32'd9, 0);

    ALUOperation = 4'b0010; a = 32'd10; b = 32'd20; start = 1'b1;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_res1", ALUResult, 32'd30);
    ALUOperation = 4'b0110; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", done, 1);
    chk("b2b_res2", ALUResult, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("b2b_done3", done, 0);

    ALUOperation = 4'b1001; a = 32'($urandom); b = 32'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_vals("rstmid");
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_nodone", cnt, 0);
    chk("rst_busy", busy, 0);
    run_op(4'b0010, 32'd2, 32'd3, 0);

    repeat (150) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op(op, rnd_val(), rnd_val(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
